hazard_controller: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32I core (F/D/E/M/W).
- Keeps a shadow scoreboard of destination registers for E/M/W, fed by decoder outputs in D.
- Produces per-stage stall/flush, E-stage forwarding selects and bubble insertion.
- Arbitrates three hazard sources: load-use, control redirect, data-memory wait.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_controller_if.sv | 41 ++++
 rtl/forward_unit.sv | 21 ++
 rtl/hazard_controller.sv | 145 ++++++++++++++
 tb/tb_hazard_controller.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, memory FSM states and
// the per-stage shadow record kept for E/M/W.
package hazard_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef enum logic [1:0] {
        FwdRf = 2'd0,
        FwdW  = 2'd1,
        FwdM  = 2'd2
    } fwd_sel_e;

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StMemWait = 1'b1;

    typedef struct packed {
        logic [RegAddrW-1:0] rd;
        logic                reg_write;
        logic                is_load;
    } shadow_t;

    // True when the stage will write a non-x0 register matching rs.
    function automatic logic writes_reg(input shadow_t s, input logic [RegAddrW-1:0] rs);
        return s.reg_write && (s.rd != '0) && (s.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decoder/datapath-facing signal bundle of the hazard controller.
interface hazard_controller_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned FWD_W      = 2
);
    logic                  valid_d;
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic                  rs1_used_d;
    logic                  rs2_used_d;
    logic [REG_ADDR_W-1:0] rd_d;
    logic                  reg_write_d;
    logic                  is_load_d;
    logic                  redirect_e;
    logic                  mem_req_m;
    logic                  mem_ready_m;
    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  stall_e;
    logic                  bubble_e;
    logic                  stall_m;
    logic                  bubble_w;
    logic [FWD_W-1:0]      fwd_a_e;
    logic [FWD_W-1:0]      fwd_b_e;
    logic                  mem_busy;

    modport master (
        output valid_d, rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d, is_load_d,
               redirect_e, mem_req_m, mem_ready_m,
        input  stall_f, stall_d, flush_d, stall_e, bubble_e, stall_m, bubble_w,
               fwd_a_e, fwd_b_e, mem_busy
    );

    modport slave (
        input  valid_d, rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d, is_load_d,
               redirect_e, mem_req_m, mem_ready_m,
        output stall_f, stall_d, flush_d, stall_e, bubble_e, stall_m, bubble_w,
               fwd_a_e, fwd_b_e, mem_busy
    );
endinterface

// File: rtl/forward_unit.sv
// Operand forwarding select for one E-stage source; M takes priority over W, x0 never forwards.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [RegAddrW-1:0] rs_i,
    input  logic                used_i,
    input  shadow_t             m_i,
    input  shadow_t             w_i,
    output fwd_sel_e            sel_o
);

    always_comb begin
        sel_o = FwdRf;
        if (used_i && writes_reg(m_i, rs_i)) begin
            sel_o = FwdM;
        end else if (used_i && writes_reg(w_i, rs_i)) begin
            sel_o = FwdW;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage core: E/M/W shadow scoreboard, forwarding, and arbitration
// of memory-wait, redirect and load-use hazards.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned FWD_W      = 2
) (
    input logic                clk,
    input logic                rst_n,
    hazard_controller_if.slave hz
);

    shadow_t             e_q, e_d, m_q, m_d, w_q, w_d;
    logic [RegAddrW-1:0] e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d;
    logic                e_rs1_used_q, e_rs1_used_d, e_rs2_used_q, e_rs2_used_d;
    logic [0:0]          state_q, state_d;

    logic                mem_stall, load_use, redirect_act;
    logic                stall_f, stall_d, flush_d, stall_e, bubble_e, stall_m, bubble_w;
    logic                mem_busy;
    fwd_sel_e            fwd_a, fwd_b;

    logic [RegAddrW-1:0] rs1_d, rs2_d;
    assign rs1_d = RegAddrW'(hz.rs1_d);
    assign rs2_d = RegAddrW'(hz.rs2_d);

    forward_unit u_fwd_a (
        .rs_i   (e_rs1_q),
        .used_i (e_rs1_used_q),
        .m_i    (m_q),
        .w_i    (w_q),
        .sel_o  (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_i   (e_rs2_q),
        .used_i (e_rs2_used_q),
        .m_i    (m_q),
        .w_i    (w_q),
        .sel_o  (fwd_b)
    );

    always_comb begin
        mem_stall = hz.mem_req_m && !hz.mem_ready_m && (state_q == StIdle);
        mem_stall = mem_stall || (!hz.mem_ready_m && (state_q == StMemWait));
        load_use  = e_q.is_load && hz.valid_d &&
                    ((hz.rs1_used_d && writes_reg(e_q, rs1_d)) ||
                     (hz.rs2_used_d && writes_reg(e_q, rs2_d)));
        // A redirect held during a memory wait is taken in the release cycle.
        redirect_act = hz.redirect_e && !mem_stall;

        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        stall_e  = 1'b0;
        bubble_e = 1'b0;
        stall_m  = 1'b0;
        bubble_w = 1'b0;
        mem_busy = 1'b0;
        if (mem_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
            mem_busy = (state_q == StMemWait);
        end else if (redirect_act) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
        end else if (load_use) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == StIdle) begin
            if (hz.mem_req_m && !hz.mem_ready_m) state_d = StMemWait;
        end else if (hz.mem_ready_m) begin
            state_d = StIdle;
        end

        e_d          = e_q;
        e_rs1_d      = e_rs1_q;
        e_rs2_d      = e_rs2_q;
        e_rs1_used_d = e_rs1_used_q;
        e_rs2_used_d = e_rs2_used_q;
        if (bubble_e) begin
            e_d          = '0;
            e_rs1_d      = '0;
            e_rs2_d      = '0;
            e_rs1_used_d = 1'b0;
            e_rs2_used_d = 1'b0;
        end else if (!stall_e) begin
            e_d.rd        = RegAddrW'(hz.rd_d);
            e_d.reg_write = hz.reg_write_d;
            e_d.is_load   = hz.is_load_d;
            e_rs1_d       = rs1_d;
            e_rs2_d       = rs2_d;
            e_rs1_used_d  = hz.rs1_used_d;
            e_rs2_used_d  = hz.rs2_used_d;
        end

        m_d = stall_m  ? m_q : e_q;
        w_d = bubble_w ? '0  : m_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            e_q          <= '0;
            m_q          <= '0;
            w_q          <= '0;
            e_rs1_q      <= '0;
            e_rs2_q      <= '0;
            e_rs1_used_q <= 1'b0;
            e_rs2_used_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_q          <= e_d;
            m_q          <= m_d;
            w_q          <= w_d;
            e_rs1_q      <= e_rs1_d;
            e_rs2_q      <= e_rs2_d;
            e_rs1_used_q <= e_rs1_used_d;
            e_rs2_used_q <= e_rs2_used_d;
        end
    end

    // Outputs are forced low while reset is held, even if requests are still asserted.
    assign hz.stall_f  = rst_n && stall_f;
    assign hz.stall_d  = rst_n && stall_d;
    assign hz.flush_d  = rst_n && flush_d;
    assign hz.stall_e  = rst_n && stall_e;
    assign hz.bubble_e = rst_n && bubble_e;
    assign hz.stall_m  = rst_n && stall_m;
    assign hz.bubble_w = rst_n && bubble_w;
    assign hz.mem_busy = rst_n && mem_busy;
    assign hz.fwd_a_e  = rst_n ? FWD_W'(fwd_a) : '0;
    assign hz.fwd_b_e  = rst_n ? FWD_W'(fwd_b) : '0;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller: forwarding, load-use, redirect, memory wait, reset.
module tb_hazard_controller;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    hazard_controller_if #(.REG_ADDR_W(5), .FWD_W(2)) hz ();

    hazard_controller #(.REG_ADDR_W(5), .FWD_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        hz.valid_d     = 1'b1;
        hz.rs1_d       = rs1;
        hz.rs2_d       = rs2;
        hz.rs1_used_d  = u1;
        hz.rs2_used_d  = u2;
        hz.rd_d        = rd;
        hz.reg_write_d = we;
        hz.is_load_d   = ld;
    endtask

    task automatic nop_d();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        hz.valid_d = 1'b0;
    endtask

    task automatic drain();
        nop_d();
        repeat (3) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        nop_d();
        hz.redirect_e  = 1'b0;
        hz.mem_req_m   = 1'b0;
        hz.mem_ready_m = 1'b0;
        repeat (2) tick();
        check("rst_stall_f", hz.stall_f, 0);
        check("rst_mem_busy", hz.mem_busy, 0);
        check("rst_fwd_a", hz.fwd_a_e, 0);
        #2 rst_n = 1'b1;
        tick();
        check("idle_stall_m", hz.stall_m, 0);
        check("idle_bubble_e", hz.bubble_e, 0);

        // add x5 in M, sub reads x5 in E
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        issue(5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
        nop_d(); #1;
        check("fwd_m_a", hz.fwd_a_e, 2);
        check("fwd_m_b", hz.fwd_b_e, 0);
        check("fwd_m_nostall", hz.stall_f, 0);
        drain();
        // x5 only in W
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        nop_d(); tick();
        issue(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
        nop_d(); #1;
        check("fwd_w_a", hz.fwd_a_e, 1);
        check("fwd_w_b", hz.fwd_b_e, 1);
        drain();
        // x5 in both M and W: M wins
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        issue(5'd5, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
        nop_d(); #1;
        check("fwd_mw_a", hz.fwd_a_e, 2);
        check("fwd_mw_b", hz.fwd_b_e, 0);
        drain();
        // rs1 matches but is not read
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        issue(5'd5, 5'd5, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0); tick();
        nop_d(); #1;
        check("fwd_unused_a", hz.fwd_a_e, 0);
        check("fwd_used_b", hz.fwd_b_e, 2);
        drain();

        // Load-use on rs2 = x7
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        issue(5'd2, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); #1;
        check("lu_stall_f", hz.stall_f, 1);
        check("lu_stall_d", hz.stall_d, 1);
        check("lu_bubble_e", hz.bubble_e, 1);
        check("lu_stall_e", hz.stall_e, 0);
        check("lu_flush_d", hz.flush_d, 0);
        tick();
        check("lu_once_stall", hz.stall_f, 0);
        check("lu_once_bubble", hz.bubble_e, 0);
        tick();
        nop_d(); #1;
        check("lu_fwd_b", hz.fwd_b_e, 1);
        check("lu_fwd_a", hz.fwd_a_e, 0);
        drain();

        // Load into x0 never stalls or forwards
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1); tick();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #1;
        check("x0_stall_f", hz.stall_f, 0);
        check("x0_bubble_e", hz.bubble_e, 0);
        tick();
        nop_d(); #1;
        check("x0_fwd_a", hz.fwd_a_e, 0);
        check("x0_fwd_b", hz.fwd_b_e, 0);
        drain();

        // Redirect overrides load-use
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1); tick();
        issue(5'd7, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        hz.redirect_e = 1'b1; #1;
        check("rd_flush_d", hz.flush_d, 1);
        check("rd_bubble_e", hz.bubble_e, 1);
        check("rd_stall_f", hz.stall_f, 0);
        check("rd_stall_d", hz.stall_d, 0);
        hz.redirect_e = 1'b0;
        drain();

        // Three wait cycles, redirect held throughout
        hz.redirect_e  = 1'b1;
        hz.mem_req_m   = 1'b1;
        hz.mem_ready_m = 1'b0; #1;
        check("mw1_stall_m", hz.stall_m, 1);
        check("mw1_stall_e", hz.stall_e, 1);
        check("mw1_stall_d", hz.stall_d, 1);
        check("mw1_stall_f", hz.stall_f, 1);
        check("mw1_bubble_w", hz.bubble_w, 1);
        check("mw1_mem_busy", hz.mem_busy, 0);
        check("mw1_flush_d", hz.flush_d, 0);
        tick();
        check("mw2_mem_busy", hz.mem_busy, 1);
        check("mw2_stall_m", hz.stall_m, 1);
        check("mw2_flush_d", hz.flush_d, 0);
        tick();
        check("mw3_mem_busy", hz.mem_busy, 1);
        check("mw3_bubble_w", hz.bubble_w, 1);
        tick();
        hz.mem_ready_m = 1'b1; #1;
        check("mw4_stall_m", hz.stall_m, 0);
        check("mw4_bubble_w", hz.bubble_w, 0);
        check("mw4_mem_busy", hz.mem_busy, 0);
        check("mw4_flush_d", hz.flush_d, 1);
        check("mw4_bubble_e", hz.bubble_e, 1);
        check("mw4_stall_f", hz.stall_f, 0);
        tick();
        hz.mem_req_m   = 1'b0;
        hz.mem_ready_m = 1'b0;
        hz.redirect_e  = 1'b0; #1;
        check("mw5_stall_m", hz.stall_m, 0);
        check("mw5_mem_busy", hz.mem_busy, 0);
        drain();

        // Reset during MEM_WAIT with x5 writers in flight
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
        nop_d();
        hz.mem_req_m = 1'b1;
        tick();
        check("rw_mem_busy", hz.mem_busy, 1);
        hz.redirect_e = 1'b1;
        rst_n = 1'b0; #1;
        check("rw_rst_mem_busy", hz.mem_busy, 0);
        check("rw_rst_stall_f", hz.stall_f, 0);
        check("rw_rst_stall_m", hz.stall_m, 0);
        check("rw_rst_bubble_w", hz.bubble_w, 0);
        check("rw_rst_flush_d", hz.flush_d, 0);
        check("rw_rst_bubble_e", hz.bubble_e, 0);
        hz.mem_req_m  = 1'b0;
        hz.redirect_e = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        issue(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
        nop_d(); #1;
        check("post_rst_fwd_a", hz.fwd_a_e, 0);
        check("post_rst_fwd_b", hz.fwd_b_e, 0);
        check("post_rst_stall_m", hz.stall_m, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
